sumador_restador_iter: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle 32-bit adder/subtractor.
- Processes the operands CHUNK bits per clock through a narrow carry-propagate slice, trading latency for area.
- Adds signed/unsigned set-less-than modes and a full flag set (carry, zero, negative, overflow).
- Sits beside the ALU for area-constrained builds and for the multi-cycle datapath variant, driven by a start/done handshake.

---
 rtl/sumador_restador_iter.sv | 172 +++++++++++++++++
 tb/tb_sumador_restador_iter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sumador_restador_iter.sv
// sumador_restador_iter: multi-cycle adder/subtractor with signed/unsigned
// set-less-than. The operands are consumed CHUNK bits per clock through a
// narrow carry-propagate slice, LSB chunk first. The result and flags are
// registered when the last chunk has been added.
//
// Handshake: start_i is accepted only while idle (state_o == IDLE). op_i, a_i
// and b_i are sampled on that same edge and ignored afterwards. busy_o is high
// for the WIDTH/CHUNK cycles of the computation. done_o then pulses for exactly
// one cycle, while result_o and the flags are valid. Those outputs hold their
// values until the end of the next accepted operation. start_i is ignored
// while busy_o or done_o is high.
module sumador_restador_iter #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             cout_o,
   output logic             zero_o,
   output logic             neg_o,
   output logic             ovf_o,
   output logic [1:0]       state_o
);

   localparam int NCH = WIDTH / CHUNK;
   localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCH - 1);

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SLT  = 2'b10;
   localparam logic [1:0] OP_SLTU = 2'b11;

   generate
      if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
         $error("sumador_restador_iter: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [WIDTH-1:0] a_q;       // operand A, shifted right one chunk per cycle
   logic [WIDTH-1:0] b_q;       // operand B' (B or ~B), shifted likewise
   logic [WIDTH-1:0] sum_q;     // partial sum, filled from the top down
   logic             carry_q;   // carry into the next chunk
   logic [CW-1:0]    cnt_q;     // index of the chunk being processed
   logic [1:0]       op_q;
   logic             a_msb_q;   // original MSBs, needed for overflow at the end
   logic             b_msb_q;

   logic [WIDTH-1:0] b_prime;
   logic             cin;
   logic [CHUNK:0]   chunk_add;
   logic [WIDTH-1:0] sum_next;
   logic             ovf_next;
   logic [WIDTH-1:0] res_next;

   assign state_o = state_q;

   // Operand conditioning: every mode except ADD computes A + ~B + 1.
   always_comb begin
      b_prime = (op_i == OP_ADD) ? b_i : ~b_i;
      cin     = (op_i != OP_ADD);
   end

   // One chunk of carry-propagate addition; the new chunk enters the sum
   // register at the top so that after NCH shifts it sits at its own position.
   always_comb begin
      chunk_add = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                + {{CHUNK{1'b0}}, carry_q};
      sum_next  = (sum_q >> CHUNK)
                | (WIDTH'(chunk_add[CHUNK-1:0]) << (WIDTH - CHUNK));
   end

   // Final result selection, only meaningful on the last RUN cycle.
   always_comb begin
      ovf_next = (a_msb_q == b_msb_q) && (sum_next[WIDTH-1] != a_msb_q);
      res_next = sum_next;
      if (op_q == OP_SLT) begin
         res_next    = '0;
         res_next[0] = sum_next[WIDTH-1] ^ ovf_next;
      end else if (op_q == OP_SLTU) begin
         res_next    = '0;
         res_next[0] = ~chunk_add[CHUNK];
      end
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and status outputs.
   always_comb begin
      state_d = state_q;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) state_d = S_RUN;
         end
         S_RUN: begin
            busy_o = 1'b1;
            if (cnt_q == LAST) state_d = S_DONE;
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Operand capture, chunk iteration and result/flag registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_q      <= '0;
         b_q      <= '0;
         sum_q    <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         op_q     <= 2'b00;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         result_o <= '0;
         cout_o   <= 1'b0;
         zero_o   <= 1'b0;
         neg_o    <= 1'b0;
         ovf_o    <= 1'b0;
      end else if (state_q == S_IDLE) begin
         if (start_i) begin
            a_q     <= a_i;
            b_q     <= b_prime;
            carry_q <= cin;
            cnt_q   <= '0;
            op_q    <= op_i;
            a_msb_q <= a_i[WIDTH-1];
            b_msb_q <= b_prime[WIDTH-1];
         end
      end else if (state_q == S_RUN) begin
         a_q     <= a_q >> CHUNK;
         b_q     <= b_q >> CHUNK;
         carry_q <= chunk_add[CHUNK];
         sum_q   <= sum_next;
         cnt_q   <= cnt_q + 1'b1;
         if (cnt_q == LAST) begin
            result_o <= res_next;
            cout_o   <= chunk_add[CHUNK];
            ovf_o    <= ovf_next;
            zero_o   <= (res_next == '0);
            neg_o    <= res_next[WIDTH-1];
         end
      end
   end

endmodule

// File: tb/tb_sumador_restador_iter.sv
// Bench for sumador_restador_iter: directed corner cases plus random
// operations on a CHUNK=8 and a CHUNK=32 instance, checked against an
// arithmetic reference model.
module tb_sumador_restador_iter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start8 = 1'b0;
   logic        start32 = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0;
   logic [31:0] b = '0;

   logic        busy8, done8, cout8, zero8, neg8, ovf8;
   logic [31:0] res8;
   logic [1:0]  st8;
   logic        busy32, done32, cout32, zero32, neg32, ovf32;
   logic [31:0] res32;
   logic [1:0]  st32;

   // observed outputs of the currently selected instance
   bit          use32 = 1'b0;
   logic        busy_s, done_s, cout_s, zero_s, neg_s, ovf_s;
   logic [31:0] res_s;

   int checks = 0;
   int failures = 0;

   // clock / reset block
   always #5 clk = ~clk;

   sumador_restador_iter #(.WIDTH(32), .CHUNK(8)) u_dut8 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .op_i(op), .a_i(a), .b_i(b),
      .busy_o(busy8), .done_o(done8), .result_o(res8), .cout_o(cout8),
      .zero_o(zero8), .neg_o(neg8), .ovf_o(ovf8), .state_o(st8)
   );

   sumador_restador_iter #(.WIDTH(32), .CHUNK(32)) u_dut32 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start32), .op_i(op), .a_i(a), .b_i(b),
      .busy_o(busy32), .done_o(done32), .result_o(res32), .cout_o(cout32),
      .zero_o(zero32), .neg_o(neg32), .ovf_o(ovf32), .state_o(st32)
   );

   always_comb begin
      busy_s = use32 ? busy32 : busy8;
      done_s = use32 ? done32 : done8;
      res_s  = use32 ? res32  : res8;
      cout_s = use32 ? cout32 : cout8;
      zero_s = use32 ? zero32 : zero8;
      neg_s  = use32 ? neg32  : neg8;
      ovf_s  = use32 ? ovf32  : ovf8;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on the operand values.
   function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] res, output logic cout, output logic ovf);
      longint sx = longint'($signed(x));
      longint sy = longint'($signed(y));
      longint ux = longint'({32'd0, x});
      longint uy = longint'({32'd0, y});
      longint sd;
      if (o == 2'b00) begin
         sd   = sx + sy;
         cout = (ux + uy) >= 64'sh1_0000_0000;
         res  = x + y;
      end else begin
         sd   = sx - sy;
         cout = (ux >= uy);
         if (o == 2'b01)      res = x - y;
         else if (o == 2'b10) res = (sx < sy) ? 32'd1 : 32'd0;
         else                 res = (ux < uy) ? 32'd1 : 32'd0;
      end
      ovf = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
   endfunction

   // Driver: issue one operation and check latency, busy length, the single
   // done pulse, the result/flags and that they hold afterwards. With noise
   // set, start_i stays high with changing operands while the op runs.
   task automatic run_op(input bit wide, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit noise, input string tag);
      logic [31:0] exp_res;
      logic        exp_cout, exp_ovf;
      int          nch, busy_cnt, lat;
      bit          got_done;
      model(o, x, y, exp_res, exp_cout, exp_ovf);
      nch   = wide ? 1 : 4;
      use32 = wide;
      @(negedge clk);
      op = o; a = x; b = y;
      if (wide) start32 = 1'b1; else start8 = 1'b1;
      @(posedge clk); #1;
      if (!noise) begin start8 = 1'b0; start32 = 1'b0; end
      busy_cnt = 0; got_done = 1'b0; lat = 0;
      for (int n = 1; n <= 20 && !got_done; n++) begin
         if (busy_s) busy_cnt++;
         if (noise) begin
            op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
         end
         @(posedge clk); #1;
         if (done_s) begin got_done = 1'b1; lat = n; end
      end
      start8 = 1'b0; start32 = 1'b0;
      chk({tag, ".latency"}, lat, nch);
      chk({tag, ".busy_cycles"}, busy_cnt, nch);
      chk({tag, ".busy_at_done"}, busy_s, 1'b0);
      chk({tag, ".result"}, res_s, exp_res);
      chk({tag, ".cout"}, cout_s, exp_cout);
      chk({tag, ".ovf"}, ovf_s, exp_ovf);
      chk({tag, ".zero"}, zero_s, exp_res == 32'd0);
      chk({tag, ".neg"}, neg_s, exp_res[31]);
      @(posedge clk); #1;
      chk({tag, ".done_once"}, done_s, 1'b0);
      chk({tag, ".held"}, res_s, exp_res);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".busy"}, busy_s, 1'b0);
      chk({tag, ".done"}, done_s, 1'b0);
      chk({tag, ".result"}, res_s, 32'd0);
      chk({tag, ".flags"}, {cout_s, zero_s, neg_s, ovf_s}, 4'b0000);
   endtask

   logic [31:0] corner [4] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};

   function automatic logic [31:0] rand_operand();
      if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
      return $urandom;
   endfunction

   initial begin
      // reset state of both instances
      repeat (3) @(posedge clk);
      #1;
      use32 = 1'b0; chk_all_zero("reset8");
      chk("reset8.state", st8, 2'd0);
      use32 = 1'b1; chk_all_zero("reset32");
      chk("reset32.state", st32, 2'd0);
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // directed cases
      run_op(1'b0, 2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "add_ovf");
      run_op(1'b0, 2'b01, 32'h0000_0005, 32'h0000_0005, 1'b0, "sub_zero");
      run_op(1'b0, 2'b01, 32'h0000_0000, 32'h0000_0001, 1'b0, "sub_wrap");
      run_op(1'b0, 2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "slt_neg");
      run_op(1'b0, 2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "sltu");
      run_op(1'b0, 2'b10, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, "slt_ovf");
      run_op(1'b0, 2'b00, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, "ignored_start");

      // reset in the middle of an ADD (previous result is nonzero)
      use32 = 1'b0;
      @(negedge clk);
      op = 2'b00; a = 32'h0000_00FF; b = 32'h0000_0001; start8 = 1'b1;
      @(posedge clk); #1 start8 = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("midreset");
      chk("midreset.state", st8, 2'd0);
      @(negedge clk); rst_n = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         chk("midreset.no_done", done8, 1'b0);
      end
      run_op(1'b0, 2'b00, 32'h0000_00FF, 32'h0000_0001, 1'b0, "after_reset");

      // full-width chunk instance
      run_op(1'b1, 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "w32_add_wrap");
      run_op(1'b1, 2'b10, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, "w32_slt_ovf");

      // randomized operations
      for (int i = 0; i < 40; i++)
         run_op(1'b0, 2'($urandom_range(0, 3)), rand_operand(), rand_operand(), 1'b0, "rand8");
      for (int i = 0; i < 10; i++)
         run_op(1'b1, 2'($urandom_range(0, 3)), rand_operand(), rand_operand(), 1'b0, "rand32");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
